seg_min_decoder: RTL and testbench



---
 rtl/seg_min_if.sv | 15 +
 rtl/seg_min_decoder.sv | 97 +++++++++
 tb/tb_seg_min_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_min_if.sv
// seg_min_if: segment-pattern sample bus and decoded-minute result bus
// Ports (via modports):
//   sample_en, seg1, seg10              driven by the pattern source (master)
//   min_val, min_valid, dec_err, busy   driven by the decoder (slave)
interface seg_min_if;
    logic       sample_en;
    logic [6:0] seg1;
    logic [6:0] seg10;
    logic [5:0] min_val;
    logic       min_valid;
    logic       dec_err;
    logic       busy;
    modport master (output sample_en, seg1, seg10, input min_val, min_valid, dec_err, busy);
    modport slave  (input sample_en, seg1, seg10, output min_val, min_valid, dec_err, busy);
endinterface

// File: rtl/seg_min_decoder.sv
// seg_min_decoder: recovers a binary minute (0-59) from a debounced pair of active-low 7-segment digits
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       seg_min_if.slave: sample_en/seg1/seg10 in; min_val/min_valid/dec_err/busy out
// Parameter STABLE_CNT: consecutive identical samples (1-15) needed to accept a pair.
// Optional macro SEG_LEADING_BLANK_EN: a blank tens digit (7'b1111111) reads as 0.
module seg_min_decoder #(
    parameter int STABLE_CNT = 4
) (
    input  logic      clk,
    input  logic      rst,
    seg_min_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
    localparam logic [3:0] SC = 4'(STABLE_CNT);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [13:0] prev_pair;
    logic        first_lock;
    logic [5:0]  min_val;
    logic        min_valid, dec_err;
    logic [13:0] pair;
    logic        diff, upd, acc, legal, load;
    logic [4:0]  u_dec, t_dec;
    logic [6:0]  val7;

    // {legal, digit}
    function automatic logic [4:0] dec_digit(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'd0};
            7'b1111001: return {1'b1, 4'd1};
            7'b0100100: return {1'b1, 4'd2};
            7'b0110000: return {1'b1, 4'd3};
            7'b0011001: return {1'b1, 4'd4};
            7'b0010010: return {1'b1, 4'd5};
            7'b0000010: return {1'b1, 4'd6};
            7'b1111000: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0010000: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    assign pair  = {bus.seg10, bus.seg1};
    assign u_dec = dec_digit(bus.seg1);
`ifdef SEG_LEADING_BLANK_EN
    assign t_dec = (bus.seg10 == 7'b1111111) ? {1'b1, 4'd0} : dec_digit(bus.seg10);
`else
    assign t_dec = dec_digit(bus.seg10);
`endif
    assign val7  = {3'd0, t_dec[3:0]} * 7'd10 + {3'd0, u_dec[3:0]};
    // val7 < 60 is implied by tens <= 5; kept as a cheap sanity bound
    assign legal = u_dec[4] & t_dec[4] & (t_dec[3:0] <= 4'd5) & (val7 < 7'd60);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // A sample updates tracking unless it merely repeats an already locked pair
    always_comb begin
        diff    = pair != prev_pair;
        upd     = bus.sample_en && !(state == LOCKED && !diff);
        cnt_n   = !upd ? cnt : (state == TRACK && !diff) ? ((cnt == SC) ? cnt : cnt + 4'd1) : 4'd1;
        state_n = !upd ? state : (cnt_n == SC) ? LOCKED : TRACK;
        acc     = upd && cnt_n == SC;
    end

    always_comb begin
        load     = acc && legal && (val7[5:0] != min_val || first_lock);
        bus.busy = state == TRACK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            prev_pair  <= 14'h3fff;
            first_lock <= 1'b1;
            min_val    <= 6'd0;
            min_valid  <= 1'b0;
            dec_err    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            prev_pair  <= upd ? pair : prev_pair;
            first_lock <= (acc && legal) ? 1'b0 : first_lock;
            min_val    <= load ? val7[5:0] : min_val;
            min_valid  <= load;
            dec_err    <= acc && !legal;
        end
    end

    assign bus.min_val   = min_val;
    assign bus.min_valid = min_valid;
    assign bus.dec_err   = dec_err;
endmodule

// File: tb/tb_seg_min_decoder.sv
// tb_seg_min_decoder: scoreboard bench for seg_min_decoder with STABLE_CNT=4
module tb_seg_min_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_min_if bus ();
    seg_min_decoder #(.STABLE_CNT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000,
                           D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000,
                           D9 = 7'b0010000, BL = 7'b1111111;

    // {min_valid, dec_err, busy, min_val}
    logic [8:0] sb[$];
    int vectors = 0;
    int errors = 0;

    task automatic compare(input string name);
        logic [8:0] exp, act;
        exp = sb.pop_front();
        act = {bus.min_valid, bus.dec_err, bus.busy, bus.min_val};
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b err=%b busy=%b val=%0d, want valid=%b err=%b busy=%b val=%0d",
                     name, act[8], act[7], act[6], act[5:0], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic strobe(input logic [6:0] s10, input logic [6:0] s1, input logic v, input logic e,
                          input logic b, input logic [5:0] val, input string name);
        sb.push_back({v, e, b, val});
        bus.seg10 = s10;
        bus.seg1 = s1;
        bus.sample_en = 1'b1;
        @(negedge clk);
        compare(name);
        bus.sample_en = 1'b0;
    endtask

    task automatic idle(input logic b, input logic [5:0] val, input string name);
        sb.push_back({1'b0, 1'b0, b, val});
        bus.sample_en = 1'b0;
        @(negedge clk);
        compare(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.push_back(9'd0);
        repeat (2) @(negedge clk);
        compare("reset");
        rst = 1'b0;
    endtask

    task automatic test_lock29();
        for (int i = 0; i < 3; i++) begin
            strobe(D2, D9, 1'b0, 1'b0, 1'b1, 6'd0, "lock29_track");
            idle(1'b1, 6'd0, "lock29_gap");
        end
        strobe(D2, D9, 1'b1, 1'b0, 1'b0, 6'd29, "lock29_accept");
        idle(1'b0, 6'd29, "lock29_pulse_end");
    endtask

    task automatic test_requalify();
        for (int i = 0; i < 3; i++) strobe(D3, D7, 1'b0, 1'b0, 1'b1, 6'd29, "req_37_partial");
        strobe(D2, D9, 1'b0, 1'b0, 1'b1, 6'd29, "req_29_break");
        for (int i = 0; i < 3; i++) strobe(D3, D7, 1'b0, 1'b0, 1'b1, 6'd29, "req_37_track");
        strobe(D3, D7, 1'b1, 1'b0, 1'b0, 6'd37, "req_37_accept");
        idle(1'b0, 6'd37, "req_pulse_end");
    endtask

    task automatic test_glitch();
        strobe(D1, D2, 1'b0, 1'b0, 1'b1, 6'd37, "glitch_12");
        for (int i = 0; i < 3; i++) strobe(D3, D7, 1'b0, 1'b0, 1'b1, 6'd37, "glitch_requal");
        strobe(D3, D7, 1'b0, 1'b0, 1'b0, 6'd37, "glitch_same_value");
        idle(1'b0, 6'd37, "glitch_idle");
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) strobe(D6, D0, 1'b0, 1'b0, 1'b1, 6'd37, "illegal_track");
        strobe(D6, D0, 1'b0, 1'b1, 1'b0, 6'd37, "illegal_err");
        idle(1'b0, 6'd37, "illegal_err_end");
        for (int i = 0; i < 5; i++) strobe(D6, D0, 1'b0, 1'b0, 1'b0, 6'd37, "illegal_no_repeat");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) strobe(D4, D5, 1'b0, 1'b0, 1'b1, 6'd37, "mid_45");
        rst = 1'b1;
        sb.push_back(9'd0);
        @(negedge clk);
        compare("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) strobe(D0, D0, 1'b0, 1'b0, 1'b1, 6'd0, "mid_00_track");
        strobe(D0, D0, 1'b1, 1'b0, 1'b0, 6'd0, "mid_00_first_lock");
    endtask

    task automatic test_blank();
        for (int i = 0; i < 3; i++) strobe(BL, D4, 1'b0, 1'b0, 1'b1, 6'd0, "blank_track");
`ifdef SEG_LEADING_BLANK_EN
        strobe(BL, D4, 1'b1, 1'b0, 1'b0, 6'd4, "blank_accept");
`else
        strobe(BL, D4, 1'b0, 1'b1, 1'b0, 6'd0, "blank_err");
`endif
        for (int i = 0; i < 3; i++) strobe(D0, BL, 1'b0, 1'b0, 1'b1, bus.min_val, "units_blank_track");
        strobe(D0, BL, 1'b0, 1'b1, 1'b0, bus.min_val, "units_blank_err");
    endtask

    task automatic test_back_to_back();
        logic [5:0] v;
        v = bus.min_val;
        for (int i = 0; i < 3; i++) strobe(D5, D9, 1'b0, 1'b0, 1'b1, v, "b2b_59_track");
        strobe(D5, D9, 1'b1, 1'b0, 1'b0, 6'd59, "b2b_59_accept");
        strobe(D5, D9, 1'b0, 1'b0, 1'b0, 6'd59, "b2b_59_hold");
        idle(1'b0, 6'd59, "b2b_idle");
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.seg1 = BL;
        bus.seg10 = BL;
        test_reset();
        test_lock29();
        test_requalify();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_blank();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
